// File: rtl/sensor_ctrl_if.sv
// Signal bundle between the JA ultrasonic range sensor controller and its
// surroundings: enable and raw echo in, trigger and measurement results out.
interface sensor_ctrl_if #(
  parameter int CW = 22
);
  logic          en;
  logic          echo;
  logic          trig;
  logic          parked;
  logic          sample_valid;
  logic [CW-1:0] echo_cycles;
  logic          timeout_err;

  modport master (
    output en, echo,
    input  trig, parked, sample_valid, echo_cycles, timeout_err
  );

  modport slave (
    input  en, echo,
    output trig, parked, sample_valid, echo_cycles, timeout_err
  );
endinterface

// File: rtl/sensor_ctrl.sv
// Parking-bay ultrasonic sensor sequencer: periodic trigger, echo width timing,
// near/far classification and debounced occupancy flag.
module sensor_ctrl #(
  parameter int CW              = 22,
  parameter int TRIG_CYCLES     = 1000,
  parameter int PERIOD_CYCLES   = 6000000,
  parameter int MAX_ECHO_CYCLES = 3000000,
  parameter int THRESH_CYCLES   = 58000,
  parameter int DEBOUNCE        = 3
) (
  input logic          clk,
  input logic          rst_n,
  sensor_ctrl_if.slave bus
);

  // The period counter must reach PERIOD_CYCLES-1 even when that exceeds CW bits.
  localparam int PW = ($clog2(PERIOD_CYCLES) > CW) ? $clog2(PERIOD_CYCLES) : CW;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [CW-1:0] TRIG_LAST   = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0] ECHO_MAX    = CW'(MAX_ECHO_CYCLES);
  localparam logic [CW-1:0] THRESH      = CW'(THRESH_CYCLES);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [PW-1:0] PCNT_SAT    = {PW{1'b1}};
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TRIG      = 3'd1;
  localparam logic [2:0] ST_WAIT_RISE = 3'd2;
  localparam logic [2:0] ST_MEASURE   = 3'd3;
  localparam logic [2:0] ST_HOLDOFF   = 3'd4;

  logic [2:0]    state;
  logic          echo_meta, echo_s;
  logic [CW-1:0] tcnt, ecnt;
  logic [PW-1:0] pcnt;
  logic [DW-1:0] dcnt;
  logic          trig_q, parked_q, valid_q, tout_q;
  logic [CW-1:0] echo_cycles_q;

  logic          finish, fin_timeout, near;
  logic [CW-1:0] fin_width;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_meta <= 1'b0;
      echo_s    <= 1'b0;
    end else begin
      echo_meta <= bus.echo;
      echo_s    <= echo_meta;
    end
  end

  // A sample ends on echo fall or when the echo counter hits its limit.
  always_comb begin
    finish      = 1'b0;
    fin_timeout = 1'b0;
    fin_width   = ecnt;
    case (state)
      ST_WAIT_RISE: begin
        if (ecnt == ECHO_MAX) begin
          finish      = 1'b1;
          fin_timeout = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (ecnt == ECHO_MAX) begin
          finish      = 1'b1;
          fin_timeout = 1'b1;
        end else if (!echo_s) begin
          finish = 1'b1;
        end
      end
      default: ;
    endcase
    if (fin_timeout) fin_width = ECHO_MAX;
    near = !fin_timeout && (fin_width < THRESH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      trig_q        <= 1'b0;
      parked_q      <= 1'b0;
      valid_q       <= 1'b0;
      tout_q        <= 1'b0;
      echo_cycles_q <= '0;
      tcnt          <= '0;
      ecnt          <= '0;
      pcnt          <= '0;
      dcnt          <= '0;
    end else begin
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
      trig_q  <= (state == ST_TRIG);
      if (pcnt != PCNT_SAT) pcnt <= pcnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (bus.en) begin
            state <= ST_TRIG;
            pcnt  <= '0;
            tcnt  <= '0;
          end
        end
        ST_TRIG: begin
          if (tcnt == TRIG_LAST) begin
            state <= ST_WAIT_RISE;
            ecnt  <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_WAIT_RISE: begin
          if (!finish) begin
            if (echo_s) begin
              state <= ST_MEASURE;
              ecnt  <= CW'(1);
            end else begin
              ecnt <= ecnt + 1'b1;
            end
          end
        end
        ST_MEASURE: begin
          if (!finish) ecnt <= ecnt + 1'b1;
        end
        ST_HOLDOFF: begin
          if (pcnt >= PERIOD_LAST) begin
            if (bus.en) begin
              state <= ST_TRIG;
              pcnt  <= '0;
              tcnt  <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Occupancy only flips after DEBOUNCE consecutive disagreeing samples.
      if (finish) begin
        state         <= ST_HOLDOFF;
        valid_q       <= 1'b1;
        tout_q        <= fin_timeout;
        echo_cycles_q <= fin_width;
        if (near == parked_q) begin
          dcnt <= '0;
        end else if (dcnt == DEB_LAST) begin
          parked_q <= !parked_q;
          dcnt     <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end
    end
  end

  assign bus.trig         = trig_q;
  assign bus.parked       = parked_q;
  assign bus.sample_valid = valid_q;
  assign bus.timeout_err  = tout_q;
  assign bus.echo_cycles  = echo_cycles_q;

endmodule

// File: tb/tb_sensor_ctrl.sv
// Directed bench for sensor_ctrl with small timing parameters; expected samples
// are queued when the echo is driven and matched when sample_valid pulses.
module tb_sensor_ctrl;

  localparam int CW       = 22;
  localparam int TRIG     = 4;
  localparam int PERIOD   = 200;
  localparam int MAXE     = 50;
  localparam int THRESH   = 20;
  localparam int DEB      = 3;

  typedef struct {
    int cycles;
    bit tout;
    bit parked;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   check_count = 0;
  int   pass_count = 0;
  int   sample_count = 0;
  int   last_sv_cyc = 0;
  exp_t sbq[$];
  bit   m_parked = 1'b0;
  int   m_dcnt = 0;

  // 0 means no echo at all, -1 means echo stuck high.
  int plan [18] = '{10, 10, 10, 30, 30, 10, 30, 30, 30, 10, 10, 10, 0, 0, 0, -1, 10, 10};

  sensor_ctrl_if #(.CW(CW)) bus ();

  sensor_ctrl #(
    .CW(CW), .TRIG_CYCLES(TRIG), .PERIOD_CYCLES(PERIOD),
    .MAX_ECHO_CYCLES(MAXE), .THRESH_CYCLES(THRESH), .DEBOUNCE(DEB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    check_count++;
    assert (obs === expv) pass_count++;
    else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, expv);
  endtask

  task automatic model_push(input int w, input bit tout);
    bit near;
    exp_t e;
    near = !tout && (w < THRESH);
    if (near == m_parked) m_dcnt = 0;
    else begin
      m_dcnt++;
      if (m_dcnt == DEB) begin
        m_parked = !m_parked;
        m_dcnt   = 0;
      end
    end
    e.cycles = tout ? MAXE : w;
    e.tout   = tout;
    e.parked = m_parked;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (bus.sample_valid === 1'b1) begin
        sample_count++;
        last_sv_cyc = cyc;
        if (sbq.size() == 0) check_output("unexpected_sample", bus.sample_valid, 0);
        else begin
          e = sbq.pop_front();
          check_output("echo_cycles", bus.echo_cycles, e.cycles);
          check_output("timeout_err", bus.timeout_err, e.tout);
          check_output("parked", bus.parked, e.parked);
        end
      end else if (bus.timeout_err !== 1'b0) begin
        check_output("timeout_without_valid", bus.timeout_err, 0);
      end
    end
  end

  task automatic wait_trig(output int rise);
    int n;
    rise = -1;
    n = 0;
    while (bus.trig !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    n = 0;
    while (bus.trig !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (bus.trig !== 1'b1) check_output("trig_wait", bus.trig, 1);
    else begin
      rise = cyc;
      n = 0;
      while (bus.trig === 1'b1 && n < 100) begin @(negedge clk); n++; end
      check_output("trig_width", n, TRIG);
    end
  endtask

  task automatic wait_sample(input int start);
    int n = 0;
    while (sample_count == start && n < 300) begin @(negedge clk); n++; end
    if (sample_count == start) check_output("sample_wait", sample_count - start, 1);
  endtask

  task automatic apply_stimulus(input int w);
    int start = sample_count;
    repeat (2) @(negedge clk);
    model_push(w, 1'b0);
    bus.echo = 1'b1;
    repeat (w) @(negedge clk);
    bus.echo = 1'b0;
    wait_sample(start);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_trig"}, bus.trig, 0);
    check_output({tag, "_parked"}, bus.parked, 0);
    check_output({tag, "_sample_valid"}, bus.sample_valid, 0);
    check_output({tag, "_echo_cycles"}, bus.echo_cycles, 0);
    check_output({tag, "_timeout_err"}, bus.timeout_err, 0);
  endtask

  initial begin
    int rise, prev_rise, en_cyc, start, trig_seen;
    bus.en   = 1'b0;
    bus.echo = 1'b0;

    $display("[TB] reset and idle");
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_all_zero("idle");

    $display("[TB] enable and periodic measurements");
    bus.en = 1'b1;
    en_cyc = cyc;
    prev_rise = -1;
    for (int i = 0; i < 18; i++) begin
      wait_trig(rise);
      if (prev_rise < 0) check_output("first_trig_latency", rise - en_cyc, 2);
      else check_output("trig_period", rise - prev_rise, PERIOD);
      prev_rise = rise;
      if (plan[i] > 0) apply_stimulus(plan[i]);
      else if (plan[i] == 0) begin
        start = sample_count;
        model_push(0, 1'b1);
        wait_sample(start);
        check_output("timeout_latency", last_sv_cyc - rise, TRIG + MAXE);
      end else begin
        start = sample_count;
        repeat (2) @(negedge clk);
        model_push(0, 1'b1);
        bus.echo = 1'b1;
        wait_sample(start);
        bus.echo = 1'b0;
      end
    end

    $display("[TB] drop enable mid-measurement");
    wait_trig(rise);
    check_output("trig_period", rise - prev_rise, PERIOD);
    start = sample_count;
    repeat (2) @(negedge clk);
    model_push(10, 1'b0);
    bus.echo = 1'b1;
    repeat (5) @(negedge clk);
    bus.en = 1'b0;
    repeat (5) @(negedge clk);
    bus.echo = 1'b0;
    wait_sample(start);
    trig_seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.trig === 1'b1) trig_seen++;
    end
    check_output("no_trig_after_disable", trig_seen, 0);
    check_output("parked_hold_idle", bus.parked, 1);

    $display("[TB] reset during measurement");
    bus.en = 1'b1;
    en_cyc = cyc;
    wait_trig(rise);
    check_output("idle_trig_latency", rise - en_cyc, 2);
    start = sample_count;
    repeat (2) @(negedge clk);
    bus.echo = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    m_parked = 1'b0;
    m_dcnt   = 0;
    @(negedge clk);
    bus.echo = 1'b0;
    bus.en   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check_output("no_sample_after_reset", sample_count - start, 0);
    check_output("scoreboard_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
